mips_alu: RTL and testbench
===========================

Name: mips_alu

Overview:
- Execute-stage ALU of the single-cycle/pipelined MIPS-subset datapath.
- Takes decoded opcode, R-type function field (ALU_control), register operands, shift amount and 16-bit immediate.
- Produces a 32-bit result and a branch-taken flag.
- Outputs are registered: one clock of latency, synchronous active-high reset.

Parameters:
- None (data width fixed at 32).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous active-high reset
- opcode  input  6  instruction opcode [31:26]
- rs_content  input  32  rs register value (operand A)
- rt_content  input  32  rt register value (operand B)
- shamt  input  5  shift amount [10:6]
- ALU_control  input  6  R-type funct field [5:0]; used only when opcode=000000
- immediate  input  16  instruction immediate [15:0]
- ALU_result  output  32  registered result
- sig_branch  output  1  registered branch-taken flag

Behaviour:
- Clocking:
  - All inputs are sampled on the rising clk edge.
  - ALU_result and sig_branch update on that same edge and hold until the next edge. Latency is exactly 1 cycle.
- Reset:
  - rst=1 at a rising edge sets ALU_result=0 and sig_branch=0. Reset has priority over any operation.
  - Asserting rst mid-stream discards the in-flight result.
- Immediate extension:
  - simm = sign-extended immediate.
  - zimm = zero-extended immediate.
- R-type (opcode 000000), selected by ALU_control:
  - 100000 add, 100001 addu: A+B mod 2^32, no overflow trap.
  - 100010 sub, 100011 subu: A-B mod 2^32.
  - 100100 and, 100101 or, 100110 xor, 100111 nor: bitwise.
  - 101010 slt: signed A<B gives 1, else 0. 101011 sltu: unsigned compare.
  - 000000 sll: B<<shamt. 000010 srl: B>>shamt logical. 000011 sra: B>>>shamt arithmetic.
  - 000100 sllv, 000110 srlv, 000111 srav: shift B by A[4:0].
  - Any other funct: result 0.
  - sig_branch is always 0 for R-type.
- I-type, selected by opcode:
  - 001000 addi, 001001 addiu: A+simm.
  - 001010 slti: signed A<simm. 001011 sltiu: unsigned A<simm.
  - 001100 andi, 001101 ori, 001110 xori: A op zimm.
  - 001111 lui: {immediate,16'h0}.
  - 100011 lw, 101011 sw: address A+simm.
- Branches:
  - Result for all branches is A-B mod 2^32.
  - 000100 beq: sig_branch = (A==B).
  - 000101 bne: sig_branch = (A!=B).
  - 000110 blez: sig_branch = signed A<=0.
  - 000111 bgtz: sig_branch = signed A>0.
  - sig_branch is 0 for every non-branch opcode.
- Undefined opcodes: result 0, sig_branch 0.
- Width rules:
  - All arithmetic wraps modulo 2^32.
  - Compare results are zero-extended to 32 bits.
  - Shifts by 0 pass B unchanged.
  - Shift amounts use only 5 bits (0..31).

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> ALU_result=0, sig_branch=0. Release; next edge reflects the inputs.
- XOR sequence (opcode 0, ALU_control 100110), one edge after each vector:
  - 15^12 -> 3
  - 23^2 -> 21
  - 1^35 -> 34
  - sig_branch stays 0 throughout.
- Arithmetic and compare:
  - add 0xFFFFFFFF+1 -> 0 (wrap).
  - sub 5-7 -> 0xFFFFFFFE.
  - slt rs=-1, rt=1 -> 1.
  - sltu same operands -> 0.
- Shifts:
  - sll rt=1, shamt=31 -> 0x80000000.
  - sra rt=0x80000000, shamt=4 -> 0xF8000000.
  - srlv rs=4, rt=0xF0 -> 0x0F.
- Immediate ops:
  - addi rs=10, imm=0xFFFF -> 9.
  - ori rs=0, imm=0xFFFF -> 0x0000FFFF.
  - lui imm=0x1234 -> 0x12340000.
  - lw rs=0x100, imm=0xFFFC -> 0xFC.
- Branches:
  - beq 7,7 -> sig_branch=1, result 0.
  - bne 7,7 -> 0.
  - blez rs=0 -> 1.
  - bgtz rs=-3 -> 0.
  - Undefined opcode 111111 -> result 0, sig_branch 0.

Source files
------------

// File: rtl/mips_alu.sv
// Execute-stage ALU for the MIPS-subset datapath: R-type, I-type, load/store
// address and branch evaluation, with one registered cycle of latency.
module mips_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [31:0] rs_content,
    input  logic [31:0] rt_content,
    input  logic [4:0]  shamt,
    input  logic [5:0]  ALU_control,
    input  logic [15:0] immediate,
    output logic [31:0] ALU_result,
    output logic        sig_branch
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_BLEZ  = 6'b000110,
        OP_BGTZ  = 6'b000111,
        OP_ADDI  = 6'b001000,
        OP_ADDIU = 6'b001001,
        OP_SLTI  = 6'b001010,
        OP_SLTIU = 6'b001011,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_XORI  = 6'b001110,
        OP_LUI   = 6'b001111,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL  = 6'b000000,
        FN_SRL  = 6'b000010,
        FN_SRA  = 6'b000011,
        FN_SLLV = 6'b000100,
        FN_SRLV = 6'b000110,
        FN_SRAV = 6'b000111,
        FN_ADD  = 6'b100000,
        FN_ADDU = 6'b100001,
        FN_SUB  = 6'b100010,
        FN_SUBU = 6'b100011,
        FN_AND  = 6'b100100,
        FN_OR   = 6'b100101,
        FN_XOR  = 6'b100110,
        FN_NOR  = 6'b100111,
        FN_SLT  = 6'b101010,
        FN_SLTU = 6'b101011
    } funct_e;

    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    logic [31:0] w_diff;
    logic [4:0]  w_var_sh;
    logic [31:0] w_result;
    logic        w_branch;
    logic [31:0] r_result;
    logic        r_branch;

    assign w_simm   = {{16{immediate[15]}}, immediate};
    assign w_zimm   = {16'h0000, immediate};
    assign w_diff   = rs_content - rt_content;
    assign w_var_sh = rs_content[4:0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // opcode/funct path can leave a value unassigned and infer a latch.
        w_result = '0;
        w_branch = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (ALU_control)
                    FN_ADD, FN_ADDU: w_result = rs_content + rt_content;
                    FN_SUB, FN_SUBU: w_result = w_diff;
                    FN_AND:  w_result = rs_content & rt_content;
                    FN_OR:   w_result = rs_content | rt_content;
                    FN_XOR:  w_result = rs_content ^ rt_content;
                    FN_NOR:  w_result = ~(rs_content | rt_content);
                    FN_SLT:  w_result = {31'b0, $signed(rs_content) < $signed(rt_content)};
                    FN_SLTU: w_result = {31'b0, rs_content < rt_content};
                    FN_SLL:  w_result = rt_content << shamt;
                    FN_SRL:  w_result = rt_content >> shamt;
                    FN_SRA:  w_result = $signed(rt_content) >>> shamt;
                    FN_SLLV: w_result = rt_content << w_var_sh;
                    FN_SRLV: w_result = rt_content >> w_var_sh;
                    FN_SRAV: w_result = $signed(rt_content) >>> w_var_sh;
                    default: w_result = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: w_result = rs_content + w_simm;
            OP_SLTI:  w_result = {31'b0, $signed(rs_content) < $signed(w_simm)};
            OP_SLTIU: w_result = {31'b0, rs_content < w_simm};
            OP_ANDI:  w_result = rs_content & w_zimm;
            OP_ORI:   w_result = rs_content | w_zimm;
            OP_XORI:  w_result = rs_content ^ w_zimm;
            OP_LUI:   w_result = {immediate, 16'h0000};
            // Branches report A-B as the result alongside the taken flag.
            OP_BEQ: begin
                w_result = w_diff;
                w_branch = (rs_content == rt_content);
            end
            OP_BNE: begin
                w_result = w_diff;
                w_branch = (rs_content != rt_content);
            end
            OP_BLEZ: begin
                w_result = w_diff;
                w_branch = rs_content[31] | (rs_content == 32'h0);
            end
            OP_BGTZ: begin
                w_result = w_diff;
                w_branch = ~rs_content[31] & (rs_content != 32'h0);
            end
            default: begin
                w_result = '0;
                w_branch = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_result <= '0;
            r_branch <= 1'b0;
        end else begin
            r_result <= w_result;
            r_branch <= w_branch;
        end
    end

    assign ALU_result = r_result;
    assign sig_branch = r_branch;

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: directed vectors push expected responses,
// a monitor pops and compares one registered result per clock.
module tb_mips_alu;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [4:0]  shamt;
    logic [5:0]  ALU_control;
    logic [15:0] immediate;
    logic [31:0] ALU_result;
    logic        sig_branch;

    typedef struct {
        logic [31:0] res;
        logic        br;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mips_alu dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .rs_content (rs_content),
        .rt_content (rt_content),
        .shamt      (shamt),
        .ALU_control(ALU_control),
        .immediate  (immediate),
        .ALU_result (ALU_result),
        .sig_branch (sig_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    // Inputs change on the falling edge; the expected response for that
    // vector is queued at the same moment and consumed after the next rise.
    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [15:0] imm,
                         input logic [31:0] er, input logic eb, input string nm);
        exp_t e;
        @(negedge clk);
        rst         = r;
        opcode      = op;
        ALU_control = fn;
        rs_content  = a;
        rt_content  = b;
        shamt       = sh;
        immediate   = imm;
        e.res  = er;
        e.br   = eb;
        e.name = nm;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check32({e.name, ".result"}, ALU_result, e.res);
                check32({e.name, ".branch"}, {31'b0, sig_branch}, {31'b0, e.br});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int wait_cycles;
        rst = 1'b1; opcode = '0; ALU_control = '0; rs_content = '0;
        rt_content = '0; shamt = '0; immediate = '0;

        for (int i = 0; i < 2; i++)
            drive(1'b1, 6'($urandom), 6'($urandom), $urandom, $urandom,
                  5'($urandom), 16'($urandom), 32'h0, 1'b0, "reset");

        // XOR sequence straight out of reset
        drive(0, 6'b000000, 6'b100110, 15, 12, 0, 16'h0, 32'd3,  0, "xor_15_12");
        drive(0, 6'b000000, 6'b100110, 23, 2,  0, 16'h0, 32'd21, 0, "xor_23_2");
        drive(0, 6'b000000, 6'b100110, 1,  35, 0, 16'h0, 32'd34, 0, "xor_1_35");

        // Arithmetic, logic and compares
        drive(0, 6'b000000, 6'b100000, 32'hFFFFFFFF, 1, 0, 16'h0, 32'h0, 0, "add_wrap");
        drive(0, 6'b000000, 6'b100001, 7, 8, 0, 16'h0, 32'd15, 0, "addu");
        drive(0, 6'b000000, 6'b100010, 5, 7, 0, 16'h0, 32'hFFFFFFFE, 0, "sub_neg");
        drive(0, 6'b000000, 6'b100011, 3, 5, 0, 16'h0, 32'hFFFFFFFE, 0, "subu");
        drive(0, 6'b000000, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 0, 16'h0, 32'hF000F000, 0, "and");
        drive(0, 6'b000000, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 0, 16'h0, 32'hFFF0FFF0, 0, "or");
        drive(0, 6'b000000, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 0, 16'h0, 32'h000F000F, 0, "nor");
        drive(0, 6'b000000, 6'b101010, 32'hFFFFFFFF, 1, 0, 16'h0, 32'd1, 0, "slt_m1_1");
        drive(0, 6'b000000, 6'b101011, 32'hFFFFFFFF, 1, 0, 16'h0, 32'd0, 0, "sltu_m1_1");
        drive(0, 6'b000000, 6'b101010, 1, 32'hFFFFFFFF, 0, 16'h0, 32'd0, 0, "slt_1_m1");
        drive(0, 6'b000000, 6'b101011, 1, 32'hFFFFFFFF, 0, 16'h0, 32'd1, 0, "sltu_1_m1");
        drive(0, 6'b000000, 6'b111111, 9, 9, 3, 16'h0, 32'h0, 0, "bad_funct");

        // Shifts
        drive(0, 6'b000000, 6'b000000, 0, 1, 31, 16'h0, 32'h80000000, 0, "sll_31");
        drive(0, 6'b000000, 6'b000000, 0, 32'hDEADBEEF, 0, 16'h0, 32'hDEADBEEF, 0, "sll_0");
        drive(0, 6'b000000, 6'b000011, 0, 32'h80000000, 4, 16'h0, 32'hF8000000, 0, "sra_4");
        drive(0, 6'b000000, 6'b000010, 0, 32'h80000000, 4, 16'h0, 32'h08000000, 0, "srl_4");
        drive(0, 6'b000000, 6'b000110, 4, 32'hF0, 0, 16'h0, 32'h0F, 0, "srlv_4");
        drive(0, 6'b000000, 6'b000100, 32'h24, 1, 0, 16'h0, 32'h10, 0, "sllv_5bit");
        drive(0, 6'b000000, 6'b000111, 1, 32'h80000000, 0, 16'h0, 32'hC0000000, 0, "srav_1");

        // Immediate forms
        drive(0, 6'b001000, 6'b0, 10, 0, 0, 16'hFFFF, 32'd9, 0, "addi_m1");
        drive(0, 6'b001001, 6'b0, 0, 0, 0, 16'h8000, 32'hFFFF8000, 0, "addiu_sext");
        drive(0, 6'b001101, 6'b0, 0, 0, 0, 16'hFFFF, 32'h0000FFFF, 0, "ori_zext");
        drive(0, 6'b001100, 6'b0, 32'hFFFFFFFF, 0, 0, 16'h8001, 32'h00008001, 0, "andi_zext");
        drive(0, 6'b001110, 6'b0, 32'hFFFF0000, 0, 0, 16'hFFFF, 32'hFFFFFFFF, 0, "xori");
        drive(0, 6'b001010, 6'b0, 32'hFFFFFFFE, 0, 0, 16'hFFFF, 32'd1, 0, "slti_m2_m1");
        drive(0, 6'b001011, 6'b0, 5, 0, 0, 16'hFFFF, 32'd1, 0, "sltiu_sext");
        drive(0, 6'b001011, 6'b0, 32'hFFFFFFFF, 0, 0, 16'h0001, 32'd0, 0, "sltiu_big");
        drive(0, 6'b001111, 6'b0, 32'h55, 0, 0, 16'h1234, 32'h12340000, 0, "lui");
        drive(0, 6'b100011, 6'b0, 32'h100, 0, 0, 16'hFFFC, 32'h000000FC, 0, "lw_addr");
        drive(0, 6'b101011, 6'b0, 32'h200, 0, 0, 16'h0004, 32'h00000204, 0, "sw_addr");

        // Branches
        drive(0, 6'b000100, 6'b0, 7, 7, 0, 16'h0, 32'h0, 1, "beq_eq");
        drive(0, 6'b000100, 6'b0, 1, 2, 0, 16'h0, 32'hFFFFFFFF, 0, "beq_ne");
        drive(0, 6'b000101, 6'b0, 7, 7, 0, 16'h0, 32'h0, 0, "bne_eq");
        drive(0, 6'b000101, 6'b0, 7, 8, 0, 16'h0, 32'hFFFFFFFF, 1, "bne_ne");
        drive(0, 6'b000110, 6'b0, 0, 0, 0, 16'h0, 32'h0, 1, "blez_0");
        drive(0, 6'b000110, 6'b0, 32'hFFFFFFFD, 0, 0, 16'h0, 32'hFFFFFFFD, 1, "blez_m3");
        drive(0, 6'b000110, 6'b0, 1, 0, 0, 16'h0, 32'd1, 0, "blez_1");
        drive(0, 6'b000111, 6'b0, 32'hFFFFFFFD, 0, 0, 16'h0, 32'hFFFFFFFD, 0, "bgtz_m3");
        drive(0, 6'b000111, 6'b0, 5, 2, 0, 16'h0, 32'd3, 1, "bgtz_5");
        drive(0, 6'b111111, 6'b100000, 7, 7, 0, 16'hFFFF, 32'h0, 0, "undef_op");

        // Reset mid-stream beats a taken branch and a nonzero add
        drive(0, 6'b000100, 6'b0, 3, 3, 0, 16'h0, 32'h0, 1, "pre_rst_beq");
        drive(1, 6'b000000, 6'b100000, 40, 2, 0, 16'h0, 32'h0, 0, "rst_mid_add");
        drive(1, 6'b000100, 6'b0, 9, 9, 0, 16'h0, 32'h0, 0, "rst_mid_beq");
        drive(0, 6'b000000, 6'b100000, 40, 2, 0, 16'h0, 32'd42, 0, "post_rst_add");

        wait_cycles = 0;
        while (q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d responses still pending, expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
